hazard_scoreboard: RTL and testbench
====================================

# hazard_scoreboard

- Parametrised decode-stage hazard detector for the MIPS pipeline.
- Tracks destination registers of the last DEPTH issued instructions in a valid-tagged shift scoreboard.
- Compares both source registers of the instruction in decode against the scoreboard and raises a same-cycle stall.
- Inserts a bubble into the scoreboard while stalled; an optional forwarding mode reduces stalls to load-use only.

## Interface
- DEPTH, 4: scoreboard slots (pipeline stages between decode and writeback); 1..8.
- CNT_W, 16: width of the stall performance counter.
- clk  in  1  pipeline clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- instr_valid_in  in  1  instr_in holds a real instruction.
- instr_in  in  32  instruction word in decode.
- flush_in  in  1  branch/jump redirect; kills the decode instruction and slot 0.
- stall_out  out  1  hold decode/fetch this cycle (combinational).
- hazard_slot_out  out  3  index of the youngest matching slot; 0 when no stall.
- stall_count_out  out  CNT_W  saturating count of stalled cycles.

## Operation
- Decode, by opcode [31:26]:
  - 000000: src rs,rt; dest rd.
  - 001xxx: src rs; dest rt.
  - 100xxx (load): src rs; dest rt; is_load=1.
  - 101xxx (store): src rs,rt; no dest.
  - 000100/000101: src rs,rt; no dest.
  - 000011: no src; dest 31.
  - All other opcodes: no src, no dest.
- Register 0 is never a source match and is never written as a valid dest.
- Slot k holds {valid, dest, is_load} of the instruction issued k+1 cycles ago.
- Hazard: instr_valid_in && !flush_in && some used src equals the dest of a valid slot.
- stall_out = hazard. hazard_slot_out = lowest matching k.
- Each rising edge: slots shift up (k → k+1) and slot DEPTH-1 is discarded.
- Slot 0 is loaded as follows:
  - Issued instruction (valid, no stall, no flush): its decoded dest.
  - Otherwise: bubble (valid=0).
  - flush_in: forced bubble, and old slot 0 is dropped instead of shifted.
- stall_count_out increments on every cycle with stall_out=1 and saturates at all-ones.

## Timing
- stall_out and hazard_slot_out are combinational from instr_in, instr_valid_in, flush_in and registered slots; there are no registered outputs other than the counter.
- A dest issued at edge t occupies slot 0 after t, and slot DEPTH-1 after t+DEPTH-1. It clears after edge t+DEPTH.
- Without forwarding, an immediately dependent instruction stalls exactly DEPTH cycles.
- Reset values: all slots invalid, stall_out=0, hazard_slot_out=0, stall_count_out=0.
- Reset mid-stall drops stall_out in the same cycle.
- Flush and hazard in the same cycle: flush wins, stall_out=0, and no entry is inserted.
- instr_valid_in=0: stall_out=0 and a bubble is shifted in.
- DEPTH=1: only slot 0 is present; the shift logic degenerates to a load.

## Configuration
- HAZARD_FORWARD_EN defined: a match counts only if it is slot 0 with is_load=1, so stalls reduce to load-use and last 1 cycle. hazard_slot_out is then always 0.
- HAZARD_FORWARD_EN undefined: any valid matching slot stalls (full interlock).

## Structure
- Shared package hazard_pkg holds:
  - opcode constants (OP_RTYPE, OP_JAL, OP_BEQ, OP_BNE, imm/load/store class prefixes);
  - REG_W=5, REG_ZERO, REG_RA;
  - the scoreboard entry struct {valid, dest, is_load}.
- Sub-module instr_reg_decode: combinational, instr → src1, src2, src1_used, src2_used, dest, dest_valid, is_load. It is reused by forwarding logic later.

## Test plan
- No forwarding, DEPTH=4, addi $1,$0,5 (0x20010005) then add $2,$1,$1 (0x00211020) held in decode:
  - stall_out=1 for 4 cycles with hazard_slot_out 0,1,2,3, then 0;
  - stall_count_out=4.
- HAZARD_FORWARD_EN, same sequence → no stall.
- HAZARD_FORWARD_EN, lw $3,0($1) (0x8C230000) then add $4,$3,$3 (0x00632020) → exactly 1 stall cycle.
- addi $0,$0,1 (0x20000001) then add $2,$0,$0 → no stall. jal (0x0C000000) then sw $31,0($0) (0xAC1F0000) → stall DEPTH cycles (no fwd).
- addi $1 issued, flush_in=1 the next cycle, then add $2,$1,$1 → no stall and no entry inserted during the flush cycle.
- reset pulsed during cycle 2 of a stall → stall_out=0 immediately, counter=0, and the next dependent pair stalls the full DEPTH again.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared decode constants and scoreboard entry type for the MIPS decode-stage hazard logic.
package hazard_pkg;

    localparam int REG_W = 5;
    localparam logic [REG_W-1:0] REG_ZERO = 5'd0;
    localparam logic [REG_W-1:0] REG_RA   = 5'd31;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;

    // Class prefixes matched against opcode[5:3]
    localparam logic [2:0] OPC_IMM   = 3'b001;
    localparam logic [2:0] OPC_LOAD  = 3'b100;
    localparam logic [2:0] OPC_STORE = 3'b101;

    typedef struct packed {
        logic             valid;
        logic [REG_W-1:0] dest;
        logic             is_load;
    } sb_entry_t;

endpackage

// File: rtl/instr_reg_decode.sv
// Combinational register-usage decode: which sources an instruction reads and which register it writes.
import hazard_pkg::*;

module instr_reg_decode (
    input  logic [31:0]      instr,
    output logic [REG_W-1:0] src1,
    output logic [REG_W-1:0] src2,
    output logic             src1_used,
    output logic             src2_used,
    output logic [REG_W-1:0] dest,
    output logic             dest_valid,
    output logic             is_load
);

    logic [5:0]       op;
    logic [REG_W-1:0] rs, rt, rd;
    logic             u1, u2, dv, ld;
    logic [REG_W-1:0] d;
    logic             unused_bits;

    assign op = instr[31:26];
    assign rs = instr[25:21];
    assign rt = instr[20:16];
    assign rd = instr[15:11];
    assign unused_bits = ^instr[10:0];

    always_comb begin
        u1 = 1'b0;
        u2 = 1'b0;
        dv = 1'b0;
        ld = 1'b0;
        d  = rd;
        if (op == OP_RTYPE) begin
            u1 = 1'b1;
            u2 = 1'b1;
            dv = 1'b1;
        end else if (op == OP_JAL) begin
            d  = REG_RA;
            dv = 1'b1;
        end else if (op == OP_BEQ || op == OP_BNE) begin
            u1 = 1'b1;
            u2 = 1'b1;
        end else begin
            case (op[5:3])
                OPC_IMM:   begin u1 = 1'b1; d = rt; dv = 1'b1; end
                OPC_LOAD:  begin u1 = 1'b1; d = rt; dv = 1'b1; ld = 1'b1; end
                OPC_STORE: begin u1 = 1'b1; u2 = 1'b1; end
                default:   ;
            endcase
        end
    end

    // $zero is hard-wired: it never creates or satisfies a dependency
    assign src1       = rs;
    assign src2       = rt;
    assign src1_used  = u1 && (rs != REG_ZERO);
    assign src2_used  = u2 && (rt != REG_ZERO);
    assign dest       = d;
    assign dest_valid = dv && (d != REG_ZERO);
    assign is_load    = ld && dv && (d != REG_ZERO);

endmodule

// File: rtl/hazard_scoreboard.sv
// Decode-stage hazard detector: shift scoreboard of in-flight destinations with same-cycle stall.
// Build option HAZARD_FORWARD_EN: only a load in slot 0 stalls (load-use), otherwise full interlock.
import hazard_pkg::*;

module hazard_scoreboard #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             instr_valid_in,
    input  logic [31:0]      instr_in,
    input  logic             flush_in,
    output logic             stall_out,
    output logic [2:0]       hazard_slot_out,
    output logic [CNT_W-1:0] stall_count_out
);

`ifdef HAZARD_FORWARD_EN
    localparam logic FWD_EN = 1'b1;
`else
    localparam logic FWD_EN = 1'b0;
`endif

    logic [REG_W-1:0] src1, src2, dest;
    logic             src1_used, src2_used, dest_valid, is_load;

    sb_entry_t [DEPTH-1:0] slots, slots_nxt;
    logic      [DEPTH-1:0] slot_match;
    logic                  hit, hazard, issue;
    logic      [2:0]       hit_slot;

    instr_reg_decode u_dec (
        .instr      (instr_in),
        .src1       (src1),
        .src2       (src2),
        .src1_used  (src1_used),
        .src2_used  (src2_used),
        .dest       (dest),
        .dest_valid (dest_valid),
        .is_load    (is_load)
    );

    for (genvar k = 0; k < DEPTH; k++) begin : g_match
        logic src_hit;
        assign src_hit = slots[k].valid &&
                         ((src1_used && src1 == slots[k].dest) ||
                          (src2_used && src2 == slots[k].dest));
        // With forwarding, every producer except a load just issued can be bypassed
        assign slot_match[k] = src_hit && (!FWD_EN || (k == 0 && slots[k].is_load));
    end

    always_comb begin
        hit      = 1'b0;
        hit_slot = '0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (slot_match[k]) begin
                hit      = 1'b1;
                hit_slot = 3'(k);
            end
        end
    end

    assign hazard          = instr_valid_in && !flush_in && hit;
    assign stall_out       = hazard;
    assign hazard_slot_out = hazard ? hit_slot : 3'd0;
    assign issue           = instr_valid_in && !flush_in && !hit;

    // A flush kills the youngest in-flight entry, so slot 0 is not carried into slot 1
    always_comb begin
        slots_nxt = '0;
        for (int k = 1; k < DEPTH; k++) begin
            if (!(k == 1 && flush_in))
                slots_nxt[k] = slots[k-1];
        end
        if (issue && dest_valid)
            slots_nxt[0] = {1'b1, dest, is_load};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            slots           <= '0;
            stall_count_out <= '0;
        end else begin
            slots <= slots_nxt;
            if (hazard && stall_count_out != {CNT_W{1'b1}})
                stall_count_out <= stall_count_out + 1'b1;
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: directed scenarios plus random traffic against a queue model.
module tb_hazard_scoreboard;

    localparam int DEPTH   = 4;
    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;
`ifdef HAZARD_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif
    localparam int EXP_RAW = FWD ? 0 : DEPTH;
    localparam int EXP_LU  = FWD ? 1 : DEPTH;

    localparam logic [31:0] ADDI1 = 32'h20010005;
    localparam logic [31:0] ADD2  = 32'h00211020;
    localparam logic [31:0] LW3   = 32'h8C230000;
    localparam logic [31:0] ADD4  = 32'h00632020;
    localparam logic [31:0] ADDI0 = 32'h20000001;
    localparam logic [31:0] ADDZ  = 32'h00001020;
    localparam logic [31:0] JAL   = 32'h0C000000;
    localparam logic [31:0] SW31  = 32'hAC1F0000;
    localparam logic [31:0] ADD5  = 32'h00422820;

    logic             clk = 1'b0;
    logic             reset;
    logic             instr_valid_in;
    logic [31:0]      instr_in;
    logic             flush_in;
    logic             stall_out;
    logic [2:0]       hazard_slot_out;
    logic [CNT_W-1:0] stall_count_out;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    hazard_scoreboard #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk             (clk),
        .reset           (reset),
        .instr_valid_in  (instr_valid_in),
        .instr_in        (instr_in),
        .flush_in        (flush_in),
        .stall_out       (stall_out),
        .hazard_slot_out (hazard_slot_out),
        .stall_count_out (stall_count_out)
    );

    // Reference model: list of the last DEPTH issue cycles, newest first
    typedef struct {
        bit       v;
        bit [4:0] d;
        bit       ld;
    } ment_t;

    ment_t mq[$];
    int    m_cnt;
    bit    m_h;
    int    m_s;
    bit    m_u1, m_u2, m_dv, m_ld;
    bit [4:0] m_s1, m_s2, m_d;
    ment_t m_new;

    function automatic void mdec(input logic [31:0] i, output bit u1, output bit u2,
                                 output bit [4:0] s1, output bit [4:0] s2,
                                 output bit dv, output bit [4:0] d, output bit ld);
        bit [5:0] op;
        op = i[31:26];
        s1 = i[25:21];
        s2 = i[20:16];
        u1 = 0; u2 = 0; dv = 0; d = 0; ld = 0;
        if (op == 6'd0) begin u1 = 1; u2 = 1; d = i[15:11]; dv = 1; end
        else if (op == 6'd3) begin d = 5'd31; dv = 1; end
        else if (op == 6'd4 || op == 6'd5) begin u1 = 1; u2 = 1; end
        else if (op[5:3] == 3'b001) begin u1 = 1; d = s2; dv = 1; end
        else if (op[5:3] == 3'b100) begin u1 = 1; d = s2; dv = 1; ld = 1; end
        else if (op[5:3] == 3'b101) begin u1 = 1; u2 = 1; end
        if (s1 == 0) u1 = 0;
        if (s2 == 0) u2 = 0;
        if (d == 0) dv = 0;
        if (!dv) ld = 0;
    endfunction

    function automatic void mhaz(input bit v, input logic [31:0] i, input bit fl,
                                 output bit h, output int slot);
        bit u1, u2, dv, ld;
        bit [4:0] s1, s2, d;
        h = 0;
        slot = 0;
        if (!v || fl) return;
        mdec(i, u1, u2, s1, s2, dv, d, ld);
        for (int k = 0; k < DEPTH; k++) begin
            if (mq[k].v && ((u1 && s1 == mq[k].d) || (u2 && s2 == mq[k].d))) begin
                if (!FWD || (k == 0 && mq[k].ld)) begin
                    h = 1;
                    slot = k;
                    return;
                end
            end
        end
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mq.delete();
            for (int k = 0; k < DEPTH; k++) mq.push_back('{0, 0, 0});
            m_cnt = 0;
        end else begin
            mhaz(instr_valid_in, instr_in, flush_in, m_h, m_s);
            if (m_h && m_cnt < CNT_MAX) m_cnt++;
            mdec(instr_in, m_u1, m_u2, m_s1, m_s2, m_dv, m_d, m_ld);
            m_new = '{0, 0, 0};
            if (instr_valid_in && !flush_in && !m_h && m_dv) m_new = '{1, m_d, m_ld};
            if (flush_in) mq[0] = '{0, 0, 0};
            mq.push_front(m_new);
            void'(mq.pop_back());
        end
    end

    task automatic drive(input bit v, input logic [31:0] i, input bit fl);
        @(negedge clk);
        instr_valid_in = v;
        instr_in       = i;
        flush_in       = fl;
        #1;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1;
        instr_valid_in = 0;
        instr_in = 0;
        flush_in = 0;
        @(negedge clk);
        reset = 0;
    endtask

    // Issue a producer then hold a consumer in decode until it issues; n=-1 if it never does
    task automatic count_stalls(input logic [31:0] p, input logic [31:0] c, output int n);
        n = 0;
        drive(1, p, 0);
        for (int k = 0; k < 20; k++) begin
            drive(1, c, 0);
            if (stall_out !== 1'b1) return;
            n++;
        end
        n = -1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1;
        instr_valid_in = 1;
        instr_in = ADD2;
        flush_in = 0;
        #1;
        total++;
        if (stall_out !== 1'b0) begin bad++; $display("FAIL reset_stall got=%0b want=0", stall_out); end
        total++;
        if (hazard_slot_out !== 3'd0) begin bad++; $display("FAIL reset_slot got=%0d want=0", hazard_slot_out); end
        total++;
        if (stall_count_out !== '0) begin bad++; $display("FAIL reset_cnt got=%0d want=0", stall_count_out); end
        @(negedge clk);
        reset = 0;
        instr_valid_in = 0;
    endtask

    task automatic test_raw_stall();
        apply_reset();
        drive(1, ADDI1, 0);
        total++;
        if (stall_out !== 1'b0) begin bad++; $display("FAIL raw_producer stall got=%0b want=0", stall_out); end
        for (int c = 0; c < DEPTH; c++) begin
            drive(1, ADD2, 0);
            total++;
            if (stall_out !== !FWD || hazard_slot_out !== (FWD ? 3'd0 : 3'(c))) begin
                bad++;
                $display("FAIL raw_cycle%0d got stall=%0b slot=%0d want stall=%0b slot=%0d",
                         c, stall_out, hazard_slot_out, !FWD, FWD ? 0 : c);
            end
        end
        drive(1, ADD2, 0);
        total++;
        if (stall_out !== 1'b0 || hazard_slot_out !== 3'd0) begin
            bad++;
            $display("FAIL raw_release got stall=%0b slot=%0d want 0/0", stall_out, hazard_slot_out);
        end
        drive(0, 32'h0, 0);
        total++;
        if (stall_count_out !== CNT_W'(EXP_RAW)) begin
            bad++; $display("FAIL raw_count got=%0d want=%0d", stall_count_out, EXP_RAW);
        end
    endtask

    task automatic test_load_use();
        int n;
        apply_reset();
        count_stalls(LW3, ADD4, n);
        total++;
        if (n != EXP_LU) begin bad++; $display("FAIL load_use stalls got=%0d want=%0d", n, EXP_LU); end
        drive(0, 32'h0, 0);
        total++;
        if (stall_count_out !== CNT_W'(EXP_LU)) begin
            bad++; $display("FAIL load_use_count got=%0d want=%0d", stall_count_out, EXP_LU);
        end
    endtask

    task automatic test_reg_zero_jal();
        int n;
        apply_reset();
        count_stalls(ADDI0, ADDZ, n);
        total++;
        if (n != 0) begin bad++; $display("FAIL reg_zero stalls got=%0d want=0", n); end
        count_stalls(JAL, SW31, n);
        total++;
        if (n != EXP_RAW) begin bad++; $display("FAIL jal_sw stalls got=%0d want=%0d", n, EXP_RAW); end
    endtask

    task automatic test_flush();
        apply_reset();
        drive(1, ADDI1, 0);
        drive(1, ADD2, 1);
        total++;
        if (stall_out !== 1'b0) begin bad++; $display("FAIL flush_wins stall got=%0b want=0", stall_out); end
        drive(1, ADD5, 0);
        total++;
        if (stall_out !== 1'b0) begin bad++; $display("FAIL flush_no_insert stall got=%0b want=0", stall_out); end
        drive(1, ADD2, 0);
        total++;
        if (stall_out !== 1'b0) begin bad++; $display("FAIL flush_drop_slot0 stall got=%0b want=0", stall_out); end
        drive(0, 32'h0, 0);
        total++;
        if (stall_count_out !== '0) begin bad++; $display("FAIL flush_count got=%0d want=0", stall_count_out); end
    endtask

    task automatic test_reset_mid_stall();
        int n;
        apply_reset();
        drive(1, ADDI1, 0);
        drive(1, ADD2, 0);
        drive(1, ADD2, 0);
        reset = 1;
        #1;
        total++;
        if (stall_out !== 1'b0) begin bad++; $display("FAIL midreset_stall got=%0b want=0", stall_out); end
        total++;
        if (stall_count_out !== '0) begin bad++; $display("FAIL midreset_cnt got=%0d want=0", stall_count_out); end
        @(negedge clk);
        reset = 0;
        instr_valid_in = 0;
        count_stalls(ADDI1, ADD2, n);
        total++;
        if (n != EXP_RAW) begin bad++; $display("FAIL midreset_again got=%0d want=%0d", n, EXP_RAW); end
    endtask

    task automatic test_saturation();
        int n;
        apply_reset();
        for (int p = 0; p < 20; p++) count_stalls(LW3, ADD4, n);
        drive(0, 32'h0, 0);
        total++;
        if (stall_count_out !== CNT_W'(CNT_MAX)) begin
            bad++; $display("FAIL saturate got=%0d want=%0d", stall_count_out, CNT_MAX);
        end
    endtask

    task automatic test_random();
        logic [31:0] cur;
        bit          v, fl, h;
        int          s;
        logic [5:0]  ops [8];
        ops = '{6'h00, 6'h08, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h03, 6'h3F};
        apply_reset();
        cur = 32'h0;
        h = 0;
        for (int c = 0; c < 400; c++) begin
            if (!h) cur = {ops[$urandom_range(7)], 5'($urandom_range(3)), 5'($urandom_range(3)),
                           5'($urandom_range(3)), 11'h020};
            v  = ($urandom_range(7) != 0) || h;
            fl = ($urandom_range(15) == 0);
            drive(v, cur, fl);
            mhaz(v, cur, fl, h, s);
            total++;
            if (stall_out !== h || hazard_slot_out !== 3'(s)) begin
                bad++;
                $display("FAIL rand_c%0d instr=%h got stall=%0b slot=%0d want stall=%0b slot=%0d",
                         c, cur, stall_out, hazard_slot_out, h, s);
            end
            total++;
            if (stall_count_out !== CNT_W'(m_cnt)) begin
                bad++; $display("FAIL rand_cnt_c%0d got=%0d want=%0d", c, stall_count_out, m_cnt);
            end
        end
    endtask

    initial begin
        reset = 0;
        instr_valid_in = 0;
        instr_in = 0;
        flush_in = 0;
        for (int k = 0; k < DEPTH; k++) mq.push_back('{0, 0, 0});
        m_cnt = 0;
        #2;
        test_reset();
        test_raw_stall();
        test_load_use();
        test_reg_zero_jal();
        test_flush();
        test_reset_mid_stall();
        test_saturation();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
